// File: rtl/tama_pkg.sv
// Shared definitions for the stats reporter.
// Holds the ASCII tag bytes, line terminators, the report command code,
// frame-length constants, the reporter FSM state type and the stats snapshot
// structure.
// Build option: STATS_REPORTER_CHECKSUM_EN selects the 17-byte frame with a
// two-character XOR checksum. Without it the frame is 15 bytes.
package tama_pkg;

    localparam logic [7:0] TagH      = 8'h48;  // 'H' hunger
    localparam logic [7:0] TagA      = 8'h41;  // 'A' happiness
    localparam logic [7:0] TagL      = 8'h4C;  // 'L' health
    localparam logic [7:0] TagG      = 8'h47;  // 'G' hygiene
    localparam logic [7:0] TagE      = 8'h45;  // 'E' energy
    localparam logic [7:0] TagS      = 8'h53;  // 'S' social
    localparam logic [7:0] AsciiCr   = 8'h0D;
    localparam logic [7:0] AsciiLf   = 8'h0A;
    localparam logic [7:0] CmdReport = 8'h72;  // 'r'

    localparam int unsigned FrameLenBase = 15;
    localparam int unsigned FrameLenCsum = 17;

`ifdef STATS_REPORTER_CHECKSUM_EN
    localparam int unsigned FrameLen = FrameLenCsum;
`else
    localparam int unsigned FrameLen = FrameLenBase;
`endif

    localparam int unsigned IdxW = 5;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(FrameLen - 1);

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

    typedef struct packed {
        logic [3:0] hunger;
        logic [4:0] happiness;
        logic [3:0] health;
        logic [3:0] hygiene;
        logic [3:0] energy;
        logic [3:0] social;
    } stats_t;

endpackage

// File: rtl/hex_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
// Ports:
//   nibble  in  4  value 0..15
//   ascii   out 8  '0'..'9' (8'h30..8'h39) or 'A'..'F' (8'h41..8'h46)
module hex_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            // 8'h37 + 10 lands on 'A'
            ascii = 8'h37 + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/stats_reporter.sv
// Streams a one-line ASCII report of the pet stats to a UART transmitter.
// A report starts on any level change of 'second' or on a received 'r' byte.
// The stats are snapshotted when the frame starts, so later input changes only
// show up in the next frame. Triggers seen while a frame is in flight collapse
// into one pending request that starts the next frame after one idle cycle.
//
// Frame: H h A a a L h G h E h S h [c c] CR LF  (c c only with checksum build)
//
// Build option: STATS_REPORTER_CHECKSUM_EN adds hex(cs[7:4]), hex(cs[3:0])
// before CR, where cs is the XOR of bytes 0..12.
//
// Ports:
//   clk        in   1  system clock
//   reset      in   1  asynchronous, active-high reset
//   second     in   1  animation-second toggle; any level change triggers
//   cmd_byte   in   8  received UART byte
//   cmd_valid  in   1  cmd_byte valid this cycle
//   hunger, health, hygiene, energy, social  in 4  stat values
//   happiness  in   5  stat value
//   tx_data    out  8  ASCII byte to transmitter
//   tx_valid   out  1  tx_data valid
//   tx_ready   in   1  transmitter accepts tx_data
//   busy       out  1  frame in progress
module stats_reporter
    import tama_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       second,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_valid,
    input  logic [3:0] hunger,
    input  logic [4:0] happiness,
    input  logic [3:0] health,
    input  logic [3:0] hygiene,
    input  logic [3:0] energy,
    input  logic [3:0] social,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
);

    state_e          state_q, state_d;
    logic [IdxW-1:0] index_q, index_d;
    logic            pending_q, pending_d;
    stats_t          snap_q, snap_d;
    logic            second_q;

    logic            trigger;
    logic            accept;
    logic            last_byte;
    logic            use_hex;
    logic [3:0]      nibble;
    logic [7:0]      nibble_ascii;
    logic [7:0]      tag_byte;

`ifdef STATS_REPORTER_CHECKSUM_EN
    logic [7:0]      cs_q, cs_d;
`endif

    assign trigger   = (second != second_q) || (cmd_valid && (cmd_byte == CmdReport));
    assign accept    = (state_q == StSend) && tx_ready;
    assign last_byte = (index_q == LastIdx);

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        pending_d = pending_q;
        snap_d    = snap_q;

        case (state_q)
            StIdle: begin
                if (trigger || pending_q) begin
                    state_d          = StSend;
                    index_d          = '0;
                    pending_d        = 1'b0;
                    snap_d.hunger    = hunger;
                    snap_d.happiness = happiness;
                    snap_d.health    = health;
                    snap_d.hygiene   = hygiene;
                    snap_d.energy    = energy;
                    snap_d.social    = social;
                end
            end
            StSend: begin
                // Covers a trigger coinciding with the last-byte accept too.
                if (trigger) begin
                    pending_d = 1'b1;
                end
                if (accept) begin
                    if (last_byte) begin
                        state_d = StIdle;
                        index_d = '0;
                    end else begin
                        index_d = index_q + IdxW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef STATS_REPORTER_CHECKSUM_EN
    // Running XOR of the bytes as they are accepted; complete once byte 12
    // has gone, which is exactly when the checksum bytes are needed.
    always_comb begin
        cs_d = cs_q;
        if (state_q == StIdle) begin
            cs_d = '0;
        end else if (accept && (index_q <= 5'd12)) begin
            cs_d = cs_q ^ tx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q <= '0;
        end else begin
            cs_q <= cs_d;
        end
    end
`endif

    // Frame byte selection: either a fixed byte or a nibble routed to the
    // single hex converter.
    always_comb begin
        use_hex  = 1'b0;
        nibble   = '0;
        tag_byte = '0;
        case (index_q)
            5'd0:  tag_byte = TagH;
            5'd1:  begin use_hex = 1'b1; nibble = snap_q.hunger; end
            5'd2:  tag_byte = TagA;
            5'd3:  begin use_hex = 1'b1; nibble = {3'b000, snap_q.happiness[4]}; end
            5'd4:  begin use_hex = 1'b1; nibble = snap_q.happiness[3:0]; end
            5'd5:  tag_byte = TagL;
            5'd6:  begin use_hex = 1'b1; nibble = snap_q.health; end
            5'd7:  tag_byte = TagG;
            5'd8:  begin use_hex = 1'b1; nibble = snap_q.hygiene; end
            5'd9:  tag_byte = TagE;
            5'd10: begin use_hex = 1'b1; nibble = snap_q.energy; end
            5'd11: tag_byte = TagS;
            5'd12: begin use_hex = 1'b1; nibble = snap_q.social; end
`ifdef STATS_REPORTER_CHECKSUM_EN
            5'd13: begin use_hex = 1'b1; nibble = cs_q[7:4]; end
            5'd14: begin use_hex = 1'b1; nibble = cs_q[3:0]; end
            5'd15: tag_byte = AsciiCr;
            5'd16: tag_byte = AsciiLf;
`else
            5'd13: tag_byte = AsciiCr;
            5'd14: tag_byte = AsciiLf;
`endif
            default: tag_byte = '0;
        endcase
    end

    hex_ascii u_hex_ascii (
        .nibble (nibble),
        .ascii  (nibble_ascii)
    );

    // Outputs
    always_comb begin
        tx_valid = (state_q == StSend);
        busy     = (state_q == StSend);
        tx_data  = 8'h00;
        if (state_q == StSend) begin
            tx_data = use_hex ? nibble_ascii : tag_byte;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            index_q   <= '0;
            pending_q <= 1'b0;
            snap_q    <= '0;
            second_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            pending_q <= pending_d;
            snap_q    <= snap_d;
            second_q  <= second;
        end
    end

endmodule

// File: tb/tb_stats_reporter.sv
// Self-checking bench for stats_reporter: directed scenarios plus a random
// phase, all checked against a frame-level reference model.
module tb_stats_reporter;

    logic       clk = 1'b0;
    logic       reset;
    logic       second;
    logic [7:0] cmd_byte;
    logic       cmd_valid;
    logic [3:0] hunger, health, hygiene, energy, social;
    logic [4:0] happiness;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

`ifdef STATS_REPORTER_CHECKSUM_EN
    localparam int FLEN = 17;
`else
    localparam int FLEN = 15;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    logic [7:0] acc_q[$];   // bytes accepted from the DUT
    int         acc_t[$];   // cycle of each accept
    logic [7:0] exp_q[$];

    // Reference model: a frame is a byte list; busy while it is non-empty.
    bit         m_busy, m_pend, m_sec;
    logic [7:0] m_frame[$];

    stats_reporter dut (
        .clk       (clk),
        .reset     (reset),
        .second    (second),
        .cmd_byte  (cmd_byte),
        .cmd_valid (cmd_valid),
        .hunger    (hunger),
        .happiness (happiness),
        .health    (health),
        .hygiene   (hygiene),
        .energy    (energy),
        .social    (social),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex_chr(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'd0, n};
        return 8'h41 + {4'd0, n} - 8'd10;
    endfunction

    function automatic void build_frame();
        logic [7:0] cs;
        m_frame.delete();
        m_frame.push_back("H"); m_frame.push_back(hex_chr(hunger));
        m_frame.push_back("A"); m_frame.push_back(hex_chr({3'b000, happiness[4]}));
        m_frame.push_back(hex_chr(happiness[3:0]));
        m_frame.push_back("L"); m_frame.push_back(hex_chr(health));
        m_frame.push_back("G"); m_frame.push_back(hex_chr(hygiene));
        m_frame.push_back("E"); m_frame.push_back(hex_chr(energy));
        m_frame.push_back("S"); m_frame.push_back(hex_chr(social));
`ifdef STATS_REPORTER_CHECKSUM_EN
        cs = 8'h00;
        foreach (m_frame[i]) cs = cs ^ m_frame[i];
        m_frame.push_back(hex_chr(cs[7:4]));
        m_frame.push_back(hex_chr(cs[3:0]));
`else
        cs = 8'h00;
`endif
        m_frame.push_back(8'h0D);
        m_frame.push_back(8'h0A);
    endfunction

    // Model update and accept logging at the active edge (pre-edge values).
    always @(posedge clk) begin
        bit trig;
        cyc++;
        if (reset) begin
            m_busy = 1'b0;
            m_pend = 1'b0;
            m_sec  = 1'b0;
            m_frame.delete();
        end else begin
            if (tx_valid && tx_ready) begin
                acc_q.push_back(tx_data);
                acc_t.push_back(cyc);
            end
            trig  = (second != m_sec) || (cmd_valid && cmd_byte == 8'h72);
            m_sec = second;
            if (!m_busy) begin
                if (trig || m_pend) begin
                    build_frame();
                    m_busy = 1'b1;
                    m_pend = 1'b0;
                end
            end else begin
                if (trig) m_pend = 1'b1;
                if (tx_ready && m_frame.size() > 0) begin
                    void'(m_frame.pop_front());
                    if (m_frame.size() == 0) m_busy = 1'b0;
                end
            end
        end
    end

    // Continuous output check away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check_eq("tx_valid", tx_valid, m_busy);
            check_eq("busy", busy, m_busy);
            check_eq("tx_data", tx_data, m_busy ? m_frame[0] : 8'h00);
        end
    end

    task automatic wait_acc(input int n, input string tag);
        int k = 0;
        while (acc_q.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, (acc_q.size() >= n), 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        check_eq("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; second = 1'b0; cmd_byte = 8'h00; cmd_valid = 1'b0; tx_ready = 1'b1;
        hunger = 0; happiness = 0; health = 0; hygiene = 0; energy = 0; social = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx_valid", tx_valid, 1'b0);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Known-vector frame and first-byte latency
        hunger = 4'd3; happiness = 5'd26; health = 4'd15; hygiene = 4'd0;
        energy = 4'd10; social = 4'd7;
        acc_q.delete(); acc_t.delete();
        second = ~second;
        @(negedge clk);
        check_eq("latency_valid", tx_valid, 1'b1);
        check_eq("latency_H", tx_data, 8'h48);
        wait_acc(FLEN, "frame_timeout");
        exp_q = '{8'h48, 8'h33, 8'h41, 8'h31, 8'h41, 8'h4C, 8'h46, 8'h47,
                  8'h30, 8'h45, 8'h41, 8'h53, 8'h37};
`ifdef STATS_REPORTER_CHECKSUM_EN
        begin
            logic [7:0] cs = 8'h00;
            foreach (exp_q[i]) cs = cs ^ exp_q[i];
            exp_q.push_back(hex_chr(cs[7:4]));
            exp_q.push_back(hex_chr(cs[3:0]));
        end
`endif
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        check_eq("frame_len", acc_q.size(), FLEN);
        for (int i = 0; i < FLEN; i++) begin
            check_eq($sformatf("frame_b%0d", i), acc_q[i], exp_q[i]);
        end
        wait_idle();
        @(negedge clk);

        // Back-pressure at byte 4
        acc_q.delete();
        second = ~second;
        @(negedge clk);
        wait_acc(4, "stall_timeout");
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", tx_valid, 1'b1);
            check_eq("stall_data", tx_data, 8'h41);
            @(negedge clk);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        check_eq("stall_count", acc_q.size(), 5);
        check_eq("stall_next", tx_data, 8'h4C);
        wait_idle();
        @(negedge clk);

        // Three 'r' commands during one frame collapse into one extra frame
        acc_q.delete(); acc_t.delete();
        second = ~second;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            repeat (2) @(negedge clk);
            cmd_byte = 8'h72; cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        wait_acc(2 * FLEN, "pend_timeout");
        wait_idle();
        repeat (5) @(negedge clk);
        check_eq("pend_count", acc_q.size(), 2 * FLEN);
        check_eq("pend_gap", (acc_t.size() > FLEN) ? (acc_t[FLEN] - acc_t[FLEN-1]) : -1, 2);

        // Stat change mid-frame
        acc_q.delete();
        second = ~second;
        @(negedge clk);
        wait_acc(5, "snap_timeout");
        hunger = 4'd9;
        wait_acc(FLEN, "snap_timeout2");
        wait_idle();
        check_eq("snap_old", acc_q[1], 8'h33);
        acc_q.delete();
        second = ~second;
        @(negedge clk);
        wait_acc(FLEN, "snap_timeout3");
        check_eq("snap_new", acc_q[1], 8'h39);
        wait_idle();
        @(negedge clk);

        // Reset mid-frame
        acc_q.delete();
        second = ~second;
        @(negedge clk);
        wait_acc(7, "rst_mid_timeout");
        reset = 1'b1;
        second = 1'b0;
        #1;
        check_eq("rst_mid_valid", tx_valid, 1'b0);
        check_eq("rst_mid_busy", busy, 1'b0);
        check_eq("rst_mid_data", tx_data, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_idle", busy, 1'b0);
        acc_q.delete();
        second = 1'b1;
        @(negedge clk);
        wait_acc(FLEN, "post_rst_timeout");
        check_eq("post_rst_H", acc_q[0], 8'h48);
        check_eq("post_rst_LF", acc_q[FLEN-1], 8'h0A);
        wait_idle();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tx_ready  = ($urandom_range(99) < 70);
            cmd_valid = ($urandom_range(99) < 5);
            cmd_byte  = ($urandom_range(1) == 0) ? 8'h72 : 8'($urandom);
            if ($urandom_range(99) < 3) second = ~second;
            if ($urandom_range(99) < 10) begin
                hunger    = 4'($urandom);
                happiness = 5'($urandom);
                health    = 4'($urandom);
                hygiene   = 4'($urandom);
                energy    = 4'($urandom);
                social    = 4'($urandom);
            end
            reset = ($urandom_range(999) < 2);
            @(negedge clk);
        end
        reset = 1'b0; cmd_valid = 1'b0; tx_ready = 1'b1;
        @(negedge clk);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
